// File: rtl/uart_pkg.sv
// Shared constants and capture-state encoding for the UART receive FIFO.
package uart_pkg;
    localparam int DEF_BYTESIZES = 8;
    localparam int DEF_DEPTH     = 16;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_DELAY,
        CAP_WRITE
    } cap_state_e;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x BYTESIZES register file: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
    parameter int BYTESIZES = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [BYTESIZES-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [BYTESIZES-1:0] rdata
);
    logic [BYTESIZES-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Captures a byte a fixed delay after the receiver's frame-done edge and queues
// it in a first-word fall-through FIFO with a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BYTESIZES     = DEF_BYTESIZES,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int CAPTURE_DELAY = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BYTESIZES-1:0]     rx_data_in,
    input  logic                     rx_ready_in,
    output logic [BYTESIZES-1:0]     data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic                     overflow_out,
    input  logic                     clear_overflow_in
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CAPTURE_DELAY + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_DLY = CW'(CAPTURE_DELAY - 1);

    cap_state_e           state;
    logic [CW-1:0]        dly_cnt;
    logic                 ready_q;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 overflow;
    logic [BYTESIZES-1:0] rd_data;
    logic                 frame_edge, push, pop, full, empty, wr_en, drop;

    assign frame_edge = rx_ready_in & ~ready_q;
    assign push       = (state == CAP_WRITE);
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign pop        = ~empty & ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CAP_IDLE;
            dly_cnt <= '0;
            ready_q <= 1'b1;
        end else begin
            ready_q <= rx_ready_in;
            case (state)
                CAP_IDLE: if (frame_edge) begin
                    state   <= CAP_DELAY;
                    dly_cnt <= '0;
                end
                CAP_DELAY: begin
                    dly_cnt <= dly_cnt + 1'b1;
                    if (dly_cnt == LAST_DLY) state <= CAP_WRITE;
                end
                CAP_WRITE: state <= CAP_IDLE;
                default:   state <= CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)                   overflow <= 1'b1;
            else if (clear_overflow_in) overflow <= 1'b0;
        end
    end

    uart_fifo_mem #(.BYTESIZES(BYTESIZES), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rx_data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Storage is not reset, so mask the read port until something is stored.
    assign data_out     = empty ? '0 : rd_data;
    assign valid_out    = ~empty;
    assign empty_out    = empty;
    assign full_out     = full;
    assign count_out    = count;
    assign overflow_out = overflow;
endmodule
